// File: rtl/hls_macc_seq_ctrl.sv
// Sequencer/collector around hls_macc_0_obf: runs N back-to-back invocations per command and
// queues results in a FWFT FIFO. Define MACC_SEQ_PERF_EN to add RUN-cycle/invocation counters.
module hls_macc_seq_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 4,
  parameter int                TIMEOUT_CYC = 64,
  parameter logic [DATA_W-1:0] OUT30_INIT  = '0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_count,
  input  logic              cmd_acc_clear,
  input  logic              err_clear,
  output logic              macc_ap_start,
  input  logic              macc_ap_done,
  input  logic              macc_ap_ready,
  input  logic              macc_ap_idle,
  output logic [DATA_W-1:0] macc_out30_i,
  input  logic [DATA_W-1:0] macc_out13,
  input  logic [DATA_W-1:0] macc_out30_o,
  input  logic [DATA_W-1:0] macc_out31,
  input  logic              macc_out13_ap_vld,
  input  logic              macc_out30_o_ap_vld,
  input  logic              macc_out31_ap_vld,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_out13,
  output logic [DATA_W-1:0] res_out30,
  output logic [DATA_W-1:0] res_out31,
  output logic              busy,
  output logic              cmd_done,
  output logic              err_timeout,
  output logic              err_vld,
`ifdef MACC_SEQ_PERF_EN
  output logic [31:0]       perf_run_cycles,
  output logic [31:0]       perf_invocations,
`endif
  output logic              err_stray
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [WDW-1:0] TO_C    = WDW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_ERR} state_t;

  state_t            r_state, w_stateNext;
  logic [DATA_W-1:0] r_acc;
  logic [15:0]       r_remaining;
  logic [WDW-1:0]    r_wdog;
  logic [WDW-1:0]    w_wdogInc;
  logic              r_cmdDone, r_errVld, r_errStray;
  logic [DATA_W-1:0] r_mem13 [DEPTH];
  logic [DATA_W-1:0] r_mem30 [DEPTH];
  logic [DATA_W-1:0] r_mem31 [DEPTH];
  logic [AW-1:0]     r_wrPtr, r_rdPtr;
  logic [CW-1:0]     r_count;
  logic              w_fire, w_push, w_pop, w_notEmpty, w_allVld, w_stray;
  logic              w_unusedIdle;

  assign w_unusedIdle = macc_ap_idle;
  assign w_fire       = macc_ap_done & macc_ap_ready;
  assign w_allVld     = macc_out13_ap_vld & macc_out30_o_ap_vld & macc_out31_ap_vld;
  assign w_stray      = (r_state != S_RUN) &
                        (macc_ap_done | macc_out13_ap_vld | macc_out30_o_ap_vld | macc_out31_ap_vld);
  assign w_push       = (r_state == S_RUN) & w_fire;
  assign w_notEmpty   = (r_count != '0);
  assign w_pop        = w_notEmpty & res_ready;
  assign w_wdogInc    = r_wdog + WDW'(1);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // Done takes priority over the watchdog in the same cycle.
  always_comb begin
    w_stateNext   = r_state;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    macc_ap_start = 1'b0;
    err_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && cmd_count != 16'd0) w_stateNext = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (r_count < DEPTH_C) w_stateNext = S_RUN;
      end
      S_RUN: begin
        macc_ap_start = 1'b1;
        if (w_fire)                 w_stateNext = (r_remaining == 16'd1) ? S_IDLE : S_LAUNCH;
        else if (w_wdogInc == TO_C) w_stateNext = S_ERR;
      end
      S_ERR: begin
        err_timeout = 1'b1;
        if (err_clear) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc       <= OUT30_INIT;
      r_remaining <= '0;
      r_wdog      <= '0;
      r_cmdDone   <= 1'b0;
      r_errVld    <= 1'b0;
      r_errStray  <= 1'b0;
    end else begin
      r_cmdDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_remaining <= cmd_count;
            if (cmd_acc_clear)       r_acc     <= OUT30_INIT;
            if (cmd_count == 16'd0)  r_cmdDone <= 1'b1;
          end
        end
        S_LAUNCH: r_wdog <= '0;
        S_RUN: begin
          if (w_fire) begin
            r_acc       <= macc_out30_o;
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) r_cmdDone <= 1'b1;
          end else begin
            r_wdog <= w_wdogInc;
          end
        end
        S_ERR: if (err_clear) r_remaining <= '0;
        default: ;
      endcase
      if (err_clear)               r_errVld <= 1'b0;
      else if (w_push && !w_allVld) r_errVld <= 1'b1;
      if (err_clear)    r_errStray <= 1'b0;
      else if (w_stray) r_errStray <= 1'b1;
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_mem13[r_wrPtr] <= macc_out13;
      r_mem30[r_wrPtr] <= macc_out30_o;
      r_mem31[r_wrPtr] <= macc_out31;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef MACC_SEQ_PERF_EN
  logic [31:0] r_perfRun, r_perfInv;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_perfRun <= '0;
      r_perfInv <= '0;
    end else begin
      if (r_state == S_RUN && r_perfRun != '1) r_perfRun <= r_perfRun + 32'd1;
      if (w_push && r_perfInv != '1)           r_perfInv <= r_perfInv + 32'd1;
    end
  end

  assign perf_run_cycles  = r_perfRun;
  assign perf_invocations = r_perfInv;
`endif

  assign macc_out30_i = r_acc;
  assign res_valid    = w_notEmpty;
  assign res_out13    = w_notEmpty ? r_mem13[r_rdPtr] : '0;
  assign res_out30    = w_notEmpty ? r_mem30[r_rdPtr] : '0;
  assign res_out31    = w_notEmpty ? r_mem31[r_rdPtr] : '0;
  assign cmd_done     = r_cmdDone;
  assign err_vld      = r_errVld;
  assign err_stray    = r_errStray;

endmodule

// File: doc/hls_macc_seq_ctrl.md
Name: hls_macc_seq_ctrl

Overview:
- Sequencer/collector directly around hls_macc_0_obf.
- Upstream: drives ap_start and the out30_i feedback operand for N back-to-back invocations per command.
- Downstream: captures out13/out30_o/out31 on completion into a small FWFT result FIFO drained by a valid/ready consumer.
- Watchdog detects a MACC that never completes (e.g. stuck FSM) and parks in an error state.

Parameters:
- DATA_W, 32, width of each MACC result word.
- DEPTH, 4, result FIFO entries (power of 2, ≥2).
- TIMEOUT_CYC, 64, max cycles ap_start may stay high without ap_done.
- OUT30_INIT, 0, accumulator value loaded on reset/clear.

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_count  in  16  invocations to run
- cmd_acc_clear  in  1  reload accumulator with OUT30_INIT at accept
- err_clear  in  1  leave ERR state
- macc_ap_start  out  1  to MACC ap_start
- macc_ap_done  in  1  from MACC
- macc_ap_ready  in  1  from MACC
- macc_ap_idle  in  1  from MACC, status only
- macc_out30_i  out  DATA_W  accumulator fed to MACC out30_i
- macc_out13, macc_out30_o, macc_out31  in  DATA_W each  MACC results
- macc_out13_ap_vld, macc_out30_o_ap_vld, macc_out31_ap_vld  in  1 each  result strobes
- res_valid  out  1  FIFO not empty
- res_ready  in  1  consumer pop
- res_out13, res_out30, res_out31  out  DATA_W each  FIFO head
- busy  out  1  state != IDLE
- cmd_done  out  1  one-cycle pulse, command finished
- err_timeout  out  1  high in ERR
- err_vld  out  1  sticky: done seen with any result strobe low
- err_stray  out  1  sticky: done or strobe seen outside RUN

Behaviour:
- Reset (async, immediate):
  - State IDLE; FIFO empty; accumulator = OUT30_INIT; remaining count = 0; watchdog = 0.
  - All outputs 0 except cmd_ready = 1.
  - Mid-run reset drops macc_ap_start in the same instant; in-flight results are lost.
- States: IDLE, LAUNCH, RUN, ERR.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch remaining = cmd_count; if cmd_acc_clear, accumulator = OUT30_INIT.
  - cmd_count = 0: cmd_done pulses the next cycle, state stays IDLE.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - macc_ap_start = 0.
  - Go to RUN when FIFO occupancy < DEPTH, evaluated on the registered occupancy.
- RUN:
  - macc_ap_start = 1, held until the cycle macc_ap_done & macc_ap_ready is seen.
  - Watchdog increments each RUN cycle. When it reaches TIMEOUT_CYC without done, go to ERR.
  - In the done cycle:
    - Push {out13, out30_o, out31} into the FIFO.
    - Accumulator <= macc_out30_o.
    - remaining decrements.
    - If any of the three ap_vld strobes is low, set err_vld; the push still happens.
  - Next state after done: remaining was 1 → IDLE with cmd_done pulse one cycle later; else LAUNCH.
  - Minimum gap between invocations is one cycle with ap_start low.
- ERR:
  - macc_ap_start = 0, err_timeout = 1, FIFO still drains.
  - err_clear → IDLE with remaining = 0 and the accumulator retained. No cmd_done is issued.
- Watchdog clears on entry to RUN.
- macc_out30_i is driven directly from the accumulator register and is stable throughout RUN.
- FIFO:
  - First-word-fall-through; pop on res_valid & res_ready.
  - Simultaneous push and pop: occupancy unchanged, head advances correctly.
  - Pop on empty is ignored.
  - Overflow is impossible by construction: one invocation in flight, launched only with free space.
- Stray events: macc_ap_done or any ap_vld in IDLE/LAUNCH/ERR sets err_stray; no push, no accumulator update.
- err_vld and err_stray clear only on ap_rst or err_clear.
- Arithmetic: remaining is 16-bit unsigned, no wrap; results are stored unmodified.

Optional Feature:
- Macro: MACC_SEQ_PERF_EN.
- Defined: adds outputs perf_run_cycles[31:0] (cycles spent in RUN) and perf_invocations[31:0] (completed dones).
  - Both saturate at all-ones and clear on ap_rst only.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then cmd_count=3, cmd_acc_clear=1, MACC model returns out30_o = out30_i+5, 3-cycle latency, res_ready=1 → 3 FIFO entries with out30 = 5, 10, 15; cmd_done single pulse; busy low after.
- cmd_count=6, DEPTH=4, res_ready=0 → exactly 4 invocations, then state held in LAUNCH with ap_start=0; raise res_ready → remaining 2 run; 6 entries total, in order.
- MACC model never asserts done → after 64 RUN cycles err_timeout=1, ap_start=0; err_clear → IDLE, cmd_ready=1, no cmd_done.
- Done with out31_ap_vld=0 → entry still pushed, err_vld=1 and stays set until err_clear.
- cmd_count=0 → accepted, cmd_done the next cycle, ap_start never asserted; stray macc_ap_done in IDLE → err_stray=1, FIFO unchanged.
- Assert ap_rst mid-RUN with 2 entries queued → ap_start=0 immediately, res_valid=0, accumulator=OUT30_INIT.
